alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds XOR/NOR, shifts, unsigned compare and signed overflow to the existing AND/OR/ADD/SUB/SLT set.
- Adds iterative unsigned multiply and divide using a valid/ready handshake.
- Sits in the execute stage. The multi-cycle controller stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request (state IDLE)
- srca  input  WIDTH  operand A
- srcb  input  WIDTH  operand B; shifts use srcb[SHW-1:0]
- alucontrol  input  4  operation code
- out_valid  output  1  one-cycle pulse: aluout/hi/zero/overflow updated
- aluout  output  WIDTH  result (product low half, or quotient)
- hi  output  WIDTH  product high half, or remainder; 0 for all other ops
- zero  output  1  aluout == 0
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, counter=0.
  - aluout=0, hi=0, zero=1, overflow=0, out_valid=0, in_ready=1.
  - Any multiply/divide in progress is abandoned; no out_valid follows.
- Opcodes 0xxx are identical to the legacy 3-bit encoding:
  - 0000 AND, 0001 OR, 0010 ADD.
  - 0011 SLT: sign bit of the A+B sum, zero-extended.
  - 0100 AND with (−B), 0101 OR with (−B); bit2 negates B in two's complement.
  - 0110 SUB.
  - 0111 SLT as sign of A−B. The raw sign bit is kept for legacy compatibility; it is not overflow-corrected.
- Opcodes 1xxx:
  - 1000 XOR, 1001 NOR.
  - 1010 SLL, 1011 SRL, 1100 SRA, shifting A by srcb[SHW-1:0].
  - 1101 MULU, 1110 DIVU.
  - 1111 SLTU: 1 when A<B unsigned.
- Handshake: a request is accepted on a rising edge with in_valid=1 and in_ready=1. Operands and opcode are captured internally; inputs are don't-care afterwards.
- Single-cycle ops (all except 1101/1110):
  - Result is registered on the accepting edge; out_valid=1 for the following cycle.
  - in_ready stays 1, so back-to-back requests give one result per cycle.
- MULU: radix-2 shift-add over a 2·WIDTH accumulator.
  - Accepting edge: state → MUL, counter=WIDTH, in_ready=0.
  - Each cycle processes one multiplier bit and decrements counter.
  - At counter==1: register {hi,aluout} = full product, pulse out_valid, return to IDLE.
  - Latency from the accept edge to the out_valid cycle: WIDTH cycles.
- DIVU: restoring shift-subtract, same counter and latency as MULU.
  - aluout = quotient, hi = remainder.
  - srcb==0: no iteration. Result on the next edge (latency 1): aluout=all ones, hi=srca.
- in_valid while in_ready=0: ignored, not queued. The requester must hold in_valid.
- Output hold: aluout, hi, zero and overflow hold their last values between out_valid pulses.
- zero always reflects the registered aluout.
- overflow (ADD/SUB): set when both effective operands have the same sign and the sum's sign differs. Computed on the negated B for bit2=1.
- Arithmetic is modulo 2^WIDTH. Negating B of most-negative value yields itself; overflow flags it for SUB.
- States: IDLE → MUL or DIV on accept of 1101/1110. MUL/DIV → IDLE after the final iteration. No other transitions except via reset.

Test Plan:
- Legacy ops, WIDTH=32: srca=0x0000000F, srcb=0x00000005, alucontrol=0110 → next cycle out_valid=1, aluout=0x0000000A, zero=0, overflow=0. Same operands with 0111 → aluout=0.
- Overflow/zero:
  - ADD 0x7FFFFFFF+0x00000001 → aluout=0x80000000, overflow=1.
  - SUB 5−5 → aluout=0, zero=1, overflow=0.
- Shifts/compare:
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL same operands → 0x08000000.
  - SLTU 0xFFFFFFFF vs 1 → 0.
  - SLT same operands → 1.
- MULU 0xFFFFFFFF×0xFFFFFFFF:
  - in_ready=0 for 32 cycles.
  - Then out_valid with hi=0xFFFFFFFE, aluout=0x00000001.
  - A second in_valid during busy is ignored.
- DIVU:
  - 100÷7 → aluout=14, hi=2 after 32 cycles.
  - 100÷0 → next cycle aluout=0xFFFFFFFF, hi=100.
- Reset mid-MULU: assert rst_n=0 at iteration 10 → outputs immediately take reset values, in_ready=1, and no out_valid after release. Also rerun the ADD case with WIDTH=8: 0x7F+0x01 → aluout=0x80, overflow=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the execute-stage ALU.
//   Request : in_valid, in_ready, srca, srcb, alucontrol
//   Result  : out_valid, aluout, hi, zero, overflow
// master drives requests and observes results; slave is the ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [3:0]       alucontrol;
    logic             out_valid;
    logic [WIDTH-1:0] aluout;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, srca, srcb, alucontrol,
        input  in_ready, out_valid, aluout, hi, zero, overflow
    );

    modport slave (
        input  in_valid, srca, srcb, alucontrol,
        output in_ready, out_valid, aluout, hi, zero, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with iterative MULU/DIVU.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave (request handshake, operands, opcode, results)
// Single-cycle ops register on the accepting edge; MULU/DIVU hold in_ready
// low for WIDTH cycles, then pulse out_valid with {hi, aluout}.
//
// state | meaning
// IDLE  | accepts requests; single-cycle ops complete here
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = SHW + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [3:0] OP_MULU = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   aluout_q, aluout_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] b_eff, sum, alu_res;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;

    assign shamt = bus.srcb[SHW-1:0];
    assign b_eff = bus.alucontrol[2] ? (~bus.srcb + ONE) : bus.srcb;
    assign sum   = bus.srca + b_eff;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alucontrol)
            4'b0000, 4'b0100: alu_res = bus.srca & b_eff;
            4'b0001, 4'b0101: alu_res = bus.srca | b_eff;
            4'b0010, 4'b0110: begin
                alu_res = sum;
                alu_ovf = (bus.srca[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.srca[WIDTH-1]);
            end
            // Raw sign bit, deliberately not overflow-corrected.
            4'b0011, 4'b0111: alu_res[0] = sum[WIDTH-1];
            4'b1000: alu_res = bus.srca ^ bus.srcb;
            4'b1001: alu_res = ~(bus.srca | bus.srcb);
            4'b1010: alu_res = bus.srca << shamt;
            4'b1011: alu_res = bus.srca >> shamt;
            4'b1100: alu_res = $signed(bus.srca) >>> shamt;
            4'b1111: alu_res[0] = (bus.srca < bus.srcb);
            default: alu_res = '0;
        endcase
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_add, acc_q[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}. Remainder stays
    // below the divisor, so the shifted value fits in WIDTH+1 bits and the
    // trial difference's top bit is a clean borrow.
    logic [WIDTH:0]     div_rs, div_trial;
    logic [2*WIDTH-1:0] div_next;
    assign div_rs    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_rs - {1'b0, opb_q};
    assign div_next  = div_trial[WIDTH]
                     ? {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        aluout_d = aluout_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.alucontrol == OP_MULU ||
                        (bus.alucontrol == OP_DIVU && bus.srcb != '0)) begin
                        state_d = (bus.alucontrol == OP_MULU) ? S_MUL : S_DIV;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, bus.srca};
                        opb_d   = bus.srcb;
                    end else if (bus.alucontrol == OP_DIVU) begin
                        aluout_d = '1;
                        hi_d     = bus.srca;
                        ovf_d    = 1'b0;
                        valid_d  = 1'b1;
                    end else begin
                        aluout_d = alu_res;
                        hi_d     = '0;
                        ovf_d    = alu_ovf;
                        valid_d  = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    aluout_d = acc_d[WIDTH-1:0];
                    hi_d     = acc_d[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            aluout_q <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            aluout_q <= aluout_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = valid_q;
    assign bus.aluout    = aluout_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = (aluout_q == '0);
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    alu_seq #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, aluout} from the opcode rules, plain arithmetic.
    function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] lo, hv, t, nb;
        lo = 32'h0; hv = 32'h0; nb = 32'h0 - b;
        case (op)
            4'd0:  lo = a & b;
            4'd1:  lo = a | b;
            4'd2:  lo = a + b;
            4'd3:  begin t = a + b; lo = {31'h0, t[31]}; end
            4'd4:  lo = a & nb;
            4'd5:  lo = a | nb;
            4'd6:  lo = a - b;
            4'd7:  begin t = a - b; lo = {31'h0, t[31]}; end
            4'd8:  lo = a ^ b;
            4'd9:  lo = ~(a | b);
            4'd10: lo = a << b[4:0];
            4'd11: lo = a >> b[4:0];
            4'd12: lo = $signed(a) >>> b[4:0];
            4'd13: {hv, lo} = {32'h0, a} * {32'h0, b};
            4'd14: if (b == 0) begin lo = 32'hFFFFFFFF; hv = a; end
                   else begin lo = a / b; hv = a % b; end
            default: lo = (a < b) ? 32'h1 : 32'h0;
        endcase
        return {hv, lo};
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] nb;
        nb = 32'h0 - b;
        sa = longint'($signed(a));
        if (op == 4'd2)      sb = longint'($signed(b));
        else if (op == 4'd6) sb = longint'($signed(nb));
        else return 1'b0;
        s = sa + sb;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        return $urandom;
    endfunction

    // Issue one op and wait for its result. poke raises a competing request
    // while busy; it must be dropped without effect.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [63:0] exp;
        int waited;
        int exp_wait;
        exp = model_res(op, a, b);
        exp_wait = (op == 4'd13 || (op == 4'd14 && b != 0)) ? 32 : 0;
        bus.srca = a; bus.srcb = b; bus.alucontrol = op; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.srca = $urandom; bus.srcb = $urandom;
        waited = 0;
        while (!bus.out_valid && waited < 100) begin
            if (bus.in_ready) waited = 200;
            if (poke && waited == 3) begin
                bus.in_valid = 1'b1; bus.alucontrol = 4'd2;
            end
            if (poke && waited == 6) bus.in_valid = 1'b0;
            if (waited < 100) begin
                @(posedge clk); #1;
                waited++;
            end
        end
        bus.in_valid = 1'b0;
        chk({tag, " busy_cycles"}, 64'(waited), 64'(exp_wait));
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, " result"}, {bus.hi, bus.aluout}, exp);
        chk({tag, " zero"}, 64'(bus.zero), 64'(exp[31:0] == 32'h0));
        chk({tag, " overflow"}, 64'(bus.overflow), 64'(model_ovf(op, a, b)));
        @(posedge clk); #1;
        chk({tag, " pulse_end"}, 64'(bus.out_valid), 64'd0);
        chk({tag, " hold"}, {bus.hi, bus.aluout}, exp);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp_q [$];
        int seen;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.srca = '0; bus.srcb = '0; bus.alucontrol = '0;
        bus8.in_valid = 1'b0; bus8.srca = '0; bus8.srcb = '0; bus8.alucontrol = '0;
        #1;
        chk("reset aluout/hi", {bus.hi, bus.aluout}, 64'h0);
        chk("reset zero", 64'(bus.zero), 64'd1);
        chk("reset overflow", 64'(bus.overflow), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 8-bit instance ADD overflow
        bus8.srca = 8'h7F; bus8.srcb = 8'h01; bus8.alucontrol = 4'd2; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        chk("w8 add out_valid", 64'(bus8.out_valid), 64'd1);
        chk("w8 add aluout", 64'(bus8.aluout), 64'h80);
        chk("w8 add overflow", 64'(bus8.overflow), 64'd1);
        @(posedge clk); #1;

        run_op("sub 15-5", 4'd6, 32'h0000000F, 32'h00000005, 1'b0);
        run_op("slt 15,5", 4'd7, 32'h0000000F, 32'h00000005, 1'b0);
        run_op("add ovf", 4'd2, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        run_op("sub 5-5", 4'd6, 32'h5, 32'h5, 1'b0);
        run_op("sub minint", 4'd6, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("sra", 4'd12, 32'h80000000, 32'h4, 1'b0);
        run_op("srl", 4'd11, 32'h80000000, 32'h4, 1'b0);
        run_op("sltu", 4'd15, 32'hFFFFFFFF, 32'h1, 1'b0);
        run_op("slt", 4'd7, 32'hFFFFFFFF, 32'h1, 1'b0);
        run_op("mulu max", 4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        run_op("divu 100/7", 4'd14, 32'd100, 32'd7, 1'b0);
        run_op("divu 100/0", 4'd14, 32'd100, 32'd0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(15));
            if (op == 4'd13 || op == 4'd14) op = 4'd15;
            run_op("rand single", op, pick(), pick(), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            a = pick(); b = (i == 7) ? 32'h0 : pick();
            run_op((i % 2 == 0) ? "rand mulu" : "rand divu", (i % 2 == 0) ? 4'd13 : 4'd14, a, b, i[2]);
        end

        // Back-to-back single-cycle ops: one result per cycle.
        for (int i = 0; i < 25; i++) begin
            op = 4'($urandom_range(15));
            if (op == 4'd13 || op == 4'd14) op = 4'd8;
            a = pick(); b = pick();
            bus.srca = a; bus.srcb = b; bus.alucontrol = op; bus.in_valid = (i < 24);
            if (i > 0) begin
                chk("b2b out_valid", 64'(bus.out_valid), 64'd1);
                chk("b2b result", {bus.hi, bus.aluout}, exp_q.pop_front());
            end
            exp_q.push_back(model_res(op, a, b));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        exp_q.delete();

        // Reset during MULU abandons it.
        run_op("pre-reset add", 4'd2, 32'h12345678, 32'h1, 1'b0);
        bus.srca = 32'hFFFFFFFF; bus.srcb = 32'hFFFFFFFF; bus.alucontrol = 4'd13; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst aluout/hi", {bus.hi, bus.aluout}, 64'h0);
        chk("midrst zero", 64'(bus.zero), 64'd1);
        chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("midrst no out_valid", 64'(seen), 64'd0);
        run_op("post-reset mulu", 4'd13, 32'd12345, 32'd6789, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
